// File: rtl/clk_seq_pkg.sv
// Shared state encoding and sizing helpers for the clock/reset sequencer.
package clk_seq_pkg;

  localparam logic [2:0] PLL_RESET = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] STABLE    = 3'd2;
  localparam logic [2:0] RELEASE   = 3'd3;
  localparam logic [2:0] RUN       = 3'd4;
  localparam logic [2:0] FAULT     = 3'd5;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One spare bit above the largest terminal count so saturation never aliases a compare value.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    return $clog2(max2(max2(a, b), max2(c, d))) + 1;
  endfunction

  function automatic int min1_clog2(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous status inputs into the clk_in1 domain.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk_in1,
  input  logic         reset,
  input  logic [W-1:0] async_in,
  output logic [W-1:0] sync_out
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk_in1) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
    end
  end

  assign sync_out = r_sync;

endmodule

// File: rtl/clk_rst_sequencer.sv
// PLL reset/lock sequencer: pulses PLL reset, debounces lock, then enables
// gated clocks and releases per-domain resets one channel at a time.
module clk_rst_sequencer
  import clk_seq_pkg::*;
#(
  parameter int N_OUT               = 5,
  parameter int RST_PULSE_CYCLES    = 32,
  parameter int LOCK_TIMEOUT_CYCLES = 20000,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int STAGGER_CYCLES      = 16,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                                   clk_in1,
  input  logic                                   reset,
  input  logic                                   pll_locked,
  input  logic                                   restart,
  output logic                                   pll_rst,
  output logic [N_OUT-1:0]                       clk_en,
  output logic [N_OUT-1:0]                       rst_out,
  output logic                                   ready,
  output logic                                   fault,
  output logic [min1_clog2(MAX_RETRIES+1)-1:0]   retry_cnt
);

  localparam int CNT_W   = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                     LOCK_STABLE_CYCLES, STAGGER_CYCLES);
  localparam int RETRY_W = min1_clog2(MAX_RETRIES + 1);
  localparam int IDX_W   = min1_clog2(N_OUT);

  localparam logic [CNT_W-1:0]   RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STG_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N_OUT - 1);
  localparam logic [RETRY_W-1:0] RTY_MAX  = RETRY_W'(MAX_RETRIES);

  logic               w_lock_s;
  logic               w_lock_lost;
  logic [CNT_W-1:0]   w_cnt_inc;

  logic [2:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_pll_rst;
  logic [N_OUT-1:0]   r_clk_en;
  logic [N_OUT-1:0]   r_rst_out;
  logic               r_ready;
  logic               r_fault;
  logic [RETRY_W-1:0] r_retry;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk_in1  (clk_in1),
    .reset    (reset),
    .async_in (pll_locked),
    .sync_out (w_lock_s)
  );

  assign w_cnt_inc   = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
  assign w_lock_lost = !w_lock_s && (r_state == RELEASE || r_state == RUN);

  // restart shares the reset path; only the synchroniser keeps its contents.
  always_ff @(posedge clk_in1) begin
    if (reset || restart) begin
      r_state   <= PLL_RESET;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_pll_rst <= 1'b1;
      r_clk_en  <= '0;
      r_rst_out <= '1;
      r_ready   <= 1'b0;
      r_fault   <= 1'b0;
      r_retry   <= '0;
    end else if (w_lock_lost) begin
      r_state   <= PLL_RESET;
      r_cnt     <= '0;
      r_pll_rst <= 1'b1;
      r_clk_en  <= '0;
      r_rst_out <= '1;
      r_ready   <= 1'b0;
      r_retry   <= '0;
    end else begin
      case (r_state)
        PLL_RESET: begin
          if (r_cnt == RST_LAST) begin
            r_state   <= WAIT_LOCK;
            r_cnt     <= '0;
            r_pll_rst <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        WAIT_LOCK: begin
          if (w_lock_s) begin
            r_state <= STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == TO_LAST) begin
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
            if (r_retry == RTY_MAX) begin
              r_state <= FAULT;
              r_fault <= 1'b1;
            end else begin
              r_state <= PLL_RESET;
              r_retry <= r_retry + 1'b1;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        STABLE: begin
          if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == STB_LAST) begin
            r_state  <= RELEASE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_clk_en <= '1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        RELEASE: begin
          // Channels release low-index first, so a left shift walks the deasserted region up.
          if (r_cnt == STG_LAST) begin
            r_cnt     <= '0;
            r_idx     <= r_idx + 1'b1;
            r_rst_out <= r_rst_out << 1;
            if (r_idx == IDX_LAST) begin
              r_state <= RUN;
              r_ready <= 1'b1;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        RUN, FAULT: begin
        end
        default: begin
          r_state   <= PLL_RESET;
          r_cnt     <= '0;
          r_pll_rst <= 1'b1;
          r_clk_en  <= '0;
          r_rst_out <= '1;
          r_ready   <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst   = r_pll_rst;
  assign clk_en    = r_clk_en;
  assign rst_out   = r_rst_out;
  assign ready     = r_ready;
  assign fault     = r_fault;
  assign retry_cnt = r_retry;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Directed bench for clk_rst_sequencer with a phase/elapsed-time reference model.
module tb_clk_rst_sequencer;

  localparam int N   = 3;
  localparam int RP  = 4;
  localparam int TO  = 100;
  localparam int ST  = 8;
  localparam int SG  = 3;
  localparam int MR  = 2;

  localparam int P_RST = 0, P_WAIT = 1, P_STB = 2, P_REL = 3, P_RUN = 4, P_FLT = 5;

  logic         clk_in1 = 1'b0;
  logic         reset, pll_locked, restart;
  logic         pll_rst, ready, fault;
  logic [N-1:0] clk_en, rst_out;
  logic [1:0]   retry_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  clk_rst_sequencer #(
    .N_OUT(N), .RST_PULSE_CYCLES(RP), .LOCK_TIMEOUT_CYCLES(TO),
    .LOCK_STABLE_CYCLES(ST), .STAGGER_CYCLES(SG), .MAX_RETRIES(MR)
  ) dut (
    .clk_in1(clk_in1), .reset(reset), .pll_locked(pll_locked), .restart(restart),
    .pll_rst(pll_rst), .clk_en(clk_en), .rst_out(rst_out), .ready(ready),
    .fault(fault), .retry_cnt(retry_cnt)
  );

  always #5 clk_in1 = ~clk_in1;

  // Reference model: which phase we are in, how long we have been there, and the retry tally.
  int   m_ph = P_RST;
  int   m_t = 0;
  int   m_retry = 0;
  logic m_s1 = 1'b0, m_s2 = 1'b0;

  always @(posedge clk_in1) begin
    if (reset) begin
      m_s1 <= 1'b0; m_s2 <= 1'b0;
    end else begin
      m_s1 <= pll_locked; m_s2 <= m_s1;
    end
    if (reset || restart) begin
      m_ph <= P_RST; m_t <= 0; m_retry <= 0;
    end else begin
      case (m_ph)
        P_RST:  if (m_t + 1 == RP) begin m_ph <= P_WAIT; m_t <= 0; end else m_t <= m_t + 1;
        P_WAIT: if (m_s2) begin m_ph <= P_STB; m_t <= 0; end
                else if (m_t + 1 == TO) begin
                  m_t <= 0;
                  if (m_retry == MR) m_ph <= P_FLT;
                  else begin m_ph <= P_RST; m_retry <= m_retry + 1; end
                end else m_t <= m_t + 1;
        P_STB:  if (!m_s2) begin m_ph <= P_WAIT; m_t <= 0; end
                else if (m_t + 1 == ST) begin m_ph <= P_REL; m_t <= 0; end
                else m_t <= m_t + 1;
        P_REL:  if (!m_s2) begin m_ph <= P_RST; m_t <= 0; m_retry <= 0; end
                else if (m_t + 1 == N * SG) begin m_ph <= P_RUN; m_t <= 0; end
                else m_t <= m_t + 1;
        P_RUN:  if (!m_s2) begin m_ph <= P_RST; m_t <= 0; m_retry <= 0; end
        default: ;
      endcase
    end
  end

  function automatic logic [N-1:0] exp_rst(input int ph, input int t);
    logic [N-1:0] r;
    r = '1;
    if (ph == P_RUN) r = '0;
    else if (ph == P_REL)
      for (int k = 0; k < N; k++) r[k] = (t < (k + 1) * SG);
    return r;
  endfunction

  always @(negedge clk_in1) begin
    logic [10:0] got, exp;
    if (chk_en) begin
      got = {pll_rst, clk_en, rst_out, ready, fault, retry_cnt};
      exp = {(m_ph == P_RST || m_ph == P_FLT),
             ((m_ph == P_REL || m_ph == P_RUN) ? 3'b111 : 3'b000),
             exp_rst(m_ph, m_t), (m_ph == P_RUN), (m_ph == P_FLT), 2'(m_retry)};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        if (n_fail < 30)
          $display("FAIL model_cmp t=%0t got pll_rst/clk_en/rst_out/ready/fault/retry=%b required %b",
                   $time, got, exp);
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk_in1);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d required %0d", nm, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_pll_rst"}, pll_rst, 1);
    chk({pfx, "_clk_en"}, clk_en, 0);
    chk({pfx, "_rst_out"}, rst_out, 3'b111);
    chk({pfx, "_ready"}, ready, 0);
    chk({pfx, "_fault"}, fault, 0);
    chk({pfx, "_retry"}, retry_cnt, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, pulses;
    logic prev;
    reset = 1'b1; pll_locked = 1'b0; restart = 1'b0;
    tick(3);
    chk_en = 1'b1;
    chk_reset_vals("reset");

    // Nominal bring-up.
    reset = 1'b0;
    n = 0; while (pll_rst && n < 50) begin tick(1); n++; end
    chk("pll_rst_width", n, 4);
    tick(20); pll_locked = 1'b1;
    n = 0; while (clk_en != 3'b111 && n < 100) begin tick(1); n++; end
    chk("lock_to_clk_en", n, 11);
    chk("rel_entry_rst_out", rst_out, 3'b111);
    tick(3); chk("step1_rst_out", rst_out, 3'b110); chk("step1_ready", ready, 0);
    tick(3); chk("step2_rst_out", rst_out, 3'b100);
    tick(3); chk("step3_rst_out", rst_out, 3'b000); chk("step3_ready", ready, 1);

    // Lock loss in RUN.
    tick(5); pll_locked = 1'b0;
    n = 0; while (ready && n < 20) begin tick(1); n++; end
    chk("loss_latency", n, 3);
    chk("loss_rst_out", rst_out, 3'b111);
    chk("loss_clk_en", clk_en, 0);
    chk("loss_pll_rst", pll_rst, 1);

    // Lock glitch during debounce.
    n = 0; while (pll_rst && n < 50) begin tick(1); n++; end
    tick(2); pll_locked = 1'b1;
    tick(5); pll_locked = 1'b0;
    tick(1); pll_locked = 1'b1;
    n = 6; while (clk_en != 3'b111 && n < 100) begin tick(1); n++; end
    chk("glitch_to_clk_en", n, 17);
    chk("glitch_retry", retry_cnt, 0);

    // Reset after channel 0 has been released.
    n = 0; while (rst_out != 3'b110 && n < 50) begin tick(1); n++; end
    chk("ch0_released", rst_out, 3'b110);
    reset = 1'b1; pll_locked = 1'b0;
    tick(1);
    chk_reset_vals("midrel");
    reset = 1'b0;

    // Lock never arrives: two retries then fault.
    n = 0; pulses = 0; prev = 1'b0;
    while (!fault && n < 2000) begin
      if (pll_rst && !prev) pulses++;
      prev = pll_rst;
      tick(1); n++;
    end
    chk("fault_cycle", n, 312);
    chk("pll_pulses", pulses, 3);
    chk("fault_retry", retry_cnt, 2);
    tick(10);
    chk("fault_pll_rst_held", pll_rst, 1);
    chk("fault_sticky", fault, 1);

    // restart clears the fault and re-runs.
    restart = 1'b1; tick(1); restart = 1'b0;
    chk("restart_fault", fault, 0);
    chk("restart_retry", retry_cnt, 0);
    chk("restart_pll_rst", pll_rst, 1);
    pll_locked = 1'b1;
    n = 0; while (!ready && n < 200) begin tick(1); n++; end
    chk("rerun_ready", ready, 1);

    // restart landing on the final timeout edge beats the fault.
    pll_locked = 1'b0;
    n = 0; while (retry_cnt != 2'd2 && n < 1000) begin tick(1); n++; end
    chk("reach_retry2", retry_cnt, 2);
    n = 0; while (pll_rst && n < 50) begin tick(1); n++; end
    tick(TO - 1);
    chk("pre_edge_pll_rst", pll_rst, 0);
    chk("pre_edge_fault", fault, 0);
    restart = 1'b1; tick(1); restart = 1'b0;
    chk("race_fault", fault, 0);
    chk("race_pll_rst", pll_rst, 1);
    chk("race_retry", retry_cnt, 0);
    n = 0; while (pll_rst && n < 50) begin tick(1); n++; end
    chk("race_pulse_width", n, 4);

    tick(2);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
